if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, instruction buffer entries; legal values are powers of two, 2..8.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 redirect_valid  input  1  branch/jump redirect request from downstream.
REQ-006 redirect_pc  input  `REG_BUS  redirect target address.
REQ-007 imem_req_valid  output  1  fetch request to instruction memory.
REQ-008 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 imem_req_addr  output  `REG_BUS  fetch address.
REQ-010 imem_resp_valid  input  1  fetched word valid; exactly one per accepted request, at least 1 cycle after acceptance.
REQ-011 imem_resp_data  input  32  fetched instruction word.
REQ-012 inst_valid  output  1  instruction available to id_stage.
REQ-013 inst_ready  input  1  id_stage consumes the instruction this cycle.
REQ-014 inst  output  32  instruction word to id_stage.
REQ-015 inst_pc  output  `REG_BUS  address of inst.

Function
REQ-016 Request handshake: transfer when imem_req_valid & imem_req_ready; the request fields stay stable while valid is high and not yet accepted, unless a redirect occurs.
REQ-017 Output handshake: pop when inst_valid & inst_ready; inst and inst_pc stay stable while inst_valid is high and not yet popped.
REQ-018 FSM states: FETCH (no outstanding request), WAIT (one outstanding), DROP (one outstanding, response to be discarded).
REQ-019 FETCH -> WAIT on request transfer; WAIT -> FETCH on imem_resp_valid; DROP -> FETCH on imem_resp_valid, response discarded.
REQ-020 There is at most one outstanding request.
REQ-021 imem_req_valid = (state==FETCH) & (fifo_count < FIFO_DEPTH) & ~redirect_valid.
REQ-022 imem_req_addr = pc register; pc advances by 4 on request transfer; wraps modulo 2^64.
REQ-023 In WAIT, each response pushes {imem_resp_data, address of the outstanding request} into the FIFO; the space is guaranteed by REQ-021.
REQ-024 inst_valid = FIFO non-empty; inst/inst_pc = FIFO head; push and pop in the same cycle are both honoured.
REQ-025 Redirect (redirect_valid=1) takes priority over all other events in that cycle.
REQ-026 On redirect, the next pc is {redirect_pc[63:2], 2'b00} and the FIFO is flushed.
REQ-027 On redirect, a pop in the same cycle is ignored.
REQ-028 On redirect, state goes WAIT -> DROP, DROP stays DROP, and FETCH stays FETCH.
REQ-029 A response arriving in the same cycle as a redirect is discarded, and state goes to FETCH.
REQ-030 Latency: with no redirect and an empty FIFO, a response received in cycle N is presented on inst in cycle N+1.
REQ-031 Throughput: with 1-cycle memory latency and inst_ready=1, one instruction is delivered every 2 cycles.

Reset
REQ-032 While rst=1: pc=RESET_PC, state=FETCH, FIFO empty, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
REQ-033 Reset asserted mid-request: the pending response is ignored if it arrives during reset.
REQ-034 After reset deasserts, the first request carries RESET_PC; the environment guarantees no stale response arrives after reset.

Structure
REQ-035 RESET_PC default, `REG_BUS and a 32-bit `INST_BUS macro live in defines.v.
REQ-036 The FIFO is a separate sub-module, if_fifo: synchronous, with flush, push, pop, count and a FIFO_DEPTH parameter.
REQ-037 The FSM and pc are in if_stage.

Verification
REQ-038 Reset, then imem_req_ready=1, 1-cycle response 32'h00000093, inst_ready=1 -> first request addr 0x80000000; inst=32'h00000093, inst_pc=0x80000000; next request 0x80000004.
REQ-039 inst_ready=0 with 1-cycle memory -> two words buffered (count=2); imem_req_valid held 0; release inst_ready -> words delivered in order at pc 0x80000000 and 0x80000004.
REQ-040 Redirect to 0x80001002 while in WAIT -> the late response is dropped and the FIFO is emptied; the next request addr is 0x80001000 and the first delivered inst_pc is 0x80001000.
REQ-041 Redirect in the same cycle as a response and a pop -> no instruction delivered from the old stream; state FETCH; the next request carries the redirect target.
REQ-042 pc=64'hFFFF_FFFF_FFFF_FFFC fetch -> the next request addr is 64'h0.
REQ-043 rst asserted for 1 cycle while in WAIT, with the response arriving during reset -> outputs are zero; after reset, the first request is 0x80000000 and no stale instruction appears.

Source files
------------

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared types, bus-width macros and reset address for the fetch stage
`ifndef IF_STAGE_DEFINES
`define IF_STAGE_DEFINES
`define REG_BUS [63:0]
`define INST_BUS [31:0]
`endif

package if_stage_pkg;
   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DROP  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic `INST_BUS inst;
      logic `REG_BUS  pc;
   } fetch_entry_t;
endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - redirect, instruction-memory and decode-side handshakes of the fetch stage
interface if_stage_if;
   logic           redirect_valid;
   logic `REG_BUS  redirect_pc;
   logic           imem_req_valid;
   logic           imem_req_ready;
   logic `REG_BUS  imem_req_addr;
   logic           imem_resp_valid;
   logic `INST_BUS imem_resp_data;
   logic           inst_valid;
   logic           inst_ready;
   logic `INST_BUS inst;
   logic `REG_BUS  inst_pc;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
   );
endinterface

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - synchronous instruction buffer with flush; head reads as zero while empty
module if_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 96,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count,
   output logic             empty
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      do_push = push && (count_q != CW'(DEPTH));
      do_pop  = pop && (count_q != '0);
      if (flush) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_d = rd_q + AW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the buffer is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head_data = empty ? '0 : mem_q[rd_q];
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: pc, single-outstanding request FSM and buffered delivery to decode
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   if_stage_if.master bus
);
   localparam int CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

   fetch_state_e  state_q, state_d;
   logic `REG_BUS pc_q, pc_d;
   logic `REG_BUS req_pc_q, req_pc_d;

   logic          req_fire, fifo_push, fifo_pop, fifo_empty;
   logic [CW-1:0] fifo_count;
   fetch_entry_t  head, push_entry;

   assign bus.imem_req_valid = ~rst && (state_q == FETCH) && (fifo_count < CW'(FIFO_DEPTH))
                               && ~bus.redirect_valid;
   assign bus.imem_req_addr  = pc_q;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

   // A redirect flushes the buffer, so any pop or push in that cycle must be suppressed.
   assign fifo_push  = ~rst && (state_q == WAIT) && bus.imem_resp_valid && ~bus.redirect_valid;
   assign fifo_pop   = bus.inst_valid && bus.inst_ready && ~bus.redirect_valid;
   assign push_entry = '{inst: bus.imem_resp_data, pc: req_pc_q};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      if (bus.redirect_valid) begin
         pc_d = bus.redirect_pc & ~64'h3;
         unique case (state_q)
            WAIT, DROP: state_d = bus.imem_resp_valid ? FETCH : DROP;
            default:    state_d = FETCH;
         endcase
      end else begin
         unique case (state_q)
            FETCH: begin
               if (req_fire) begin
                  state_d  = WAIT;
                  req_pc_d = pc_q;
                  pc_d     = pc_q + 64'd4;
               end
            end
            WAIT, DROP: begin
               if (bus.imem_resp_valid) state_d = FETCH;
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   if_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.redirect_valid),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .head_data (head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign bus.inst_valid = ~rst && ~fifo_empty;
   assign bus.inst       = rst ? '0 : head.inst;
   assign bus.inst_pc    = rst ? '0 : head.pc;
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed and randomized checks of if_stage against a transaction-level fetch model
module tb_if_stage;
   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
   localparam int          DEPTH  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   if_stage_if bus ();

   if_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] m_pc = RST_PC;
   logic [95:0] exp_q[$];
   bit          pend = 0, stale = 0;
   int          lat = 0;
   int          lat_cfg = 0;
   logic [63:0] pend_addr = '0;
   logic [31:0] pend_data = '0;
   bit          fix_data = 0;
   logic [31:0] fix_val = '0;
   bit          seen = 0;
   logic [31:0] first_inst = '0;
   logic [63:0] first_pc = '0;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit rd, input logic [63:0] rpc, input bit rq, input bit ir);
      bit resp, exp_rv;
      @(negedge clk);
      resp = pend && (r || lat == 0);
      rst                 = r;
      bus.redirect_valid  = rd;
      bus.redirect_pc     = rpc;
      bus.imem_req_ready  = rq;
      bus.imem_resp_valid = resp;
      bus.imem_resp_data  = resp ? pend_data : $urandom;
      bus.inst_ready      = ir;
      #1;
      exp_rv = !pend && (exp_q.size() < DEPTH) && !rd;
      if (r) begin
         check("rst_req_valid", bus.imem_req_valid, 0);
         check("rst_inst_valid", bus.inst_valid, 0);
         check("rst_inst", bus.inst, 0);
         check("rst_inst_pc", bus.inst_pc, 0);
         m_pc = RST_PC;
         exp_q.delete();
         pend = 0;
         stale = 0;
      end else begin
         check("req_valid", bus.imem_req_valid, exp_rv);
         if (exp_rv) check("req_addr", bus.imem_req_addr, m_pc);
         check("inst_valid", bus.inst_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) check("inst_head", {bus.inst, bus.inst_pc}, exp_q[0]);
         if (pend && !resp && lat > 0) lat--;
         if (rd) begin
            m_pc = rpc & ~64'h3;
            exp_q.delete();
            if (pend) begin
               if (resp) pend = 0;
               else stale = 1;
            end
         end else begin
            if (ir && exp_q.size() != 0) begin
               if (!seen) begin
                  first_inst = bus.inst;
                  first_pc   = bus.inst_pc;
                  seen       = 1;
               end
               void'(exp_q.pop_front());
            end
            if (resp) begin
               if (!stale) exp_q.push_back({pend_data, pend_addr});
               pend = 0;
            end
            if (exp_rv && rq) begin
               pend      = 1;
               stale     = 0;
               pend_addr = m_pc;
               lat       = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
               pend_data = fix_data ? fix_val : $urandom;
               m_pc      = m_pc + 64'd4;
            end
         end
      end
   endtask

   task automatic run_until_pend(input bit ir);
      for (int i = 0; i < 20 && !pend; i++) step(0, 0, '0, 1, ir);
      check("wait_outstanding", pend, 1);
   endtask

   initial begin
      bus.redirect_valid  = 0;
      bus.redirect_pc     = '0;
      bus.imem_req_ready  = 0;
      bus.imem_resp_valid = 0;
      bus.imem_resp_data  = '0;
      bus.inst_ready      = 0;

      repeat (3) step(1, 0, '0, 1, 1);

      // first fetch after reset, fixed 1-cycle memory returning 0x93
      fix_data = 1; fix_val = 32'h0000_0093; lat_cfg = 0;
      repeat (5) step(0, 0, '0, 1, 1);
      check("first_inst", first_inst, 32'h0000_0093);
      check("first_pc", first_pc, 64'h8000_0000);
      fix_data = 0;

      // decode stalled: buffer fills to depth, requests stop, then drains in order
      step(1, 0, '0, 1, 1);
      repeat (8) step(0, 0, '0, 1, 0);
      check("fifo_full_count", dut.u_fifo.count, 2);
      check("full_head_pc", bus.inst_pc, 64'h8000_0000);
      repeat (6) step(0, 0, '0, 1, 1);

      // redirect while a request is outstanding
      lat_cfg = 3;
      run_until_pend(1);
      step(0, 1, 64'h0000_0000_8000_1002, 1, 1);
      lat_cfg = 0;
      check("redirect_pc_model", m_pc, 64'h8000_1000);
      repeat (8) step(0, 0, '0, 1, 1);

      // redirect coinciding with a response and a pop
      step(0, 1, 64'h0000_0000_8000_3000, 1, 1);
      for (int i = 0; i < 20 && !(exp_q.size() != 0 && pend && lat == 0); i++) step(0, 0, '0, 1, 0);
      check("setup_resp_pop", exp_q.size() != 0 && pend && lat == 0, 1);
      step(0, 1, 64'h0000_0000_8000_2000, 1, 1);
      repeat (6) step(0, 0, '0, 1, 1);

      // pc wrap at the top of the address space
      step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1);
      repeat (8) step(0, 0, '0, 1, 1);

      // reset pulse while waiting, response lands inside reset
      lat_cfg = 2;
      run_until_pend(1);
      step(1, 0, '0, 1, 1);
      lat_cfg = 0;
      repeat (6) step(0, 0, '0, 1, 1);

      lat_cfg = -1;
      for (int i = 0; i < 4000; i++) begin
         logic [63:0] tgt;
         tgt = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                           : {$urandom, $urandom};
         step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, tgt,
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
